// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its command sequencer:
// function codes, flag bit positions, sequencer states and helpers.
package alu_pkg;

   localparam int DATA_W   = 16;
   localparam int FUNSEL_W = 5;
   localparam int FLAGS_W  = 4;

   localparam logic [FUNSEL_W-1:0] ADD16 = 5'b10100;
   localparam logic [FUNSEL_W-1:0] ADC16 = 5'b10101;
   localparam logic [FUNSEL_W-1:0] SUB16 = 5'b10110;
   localparam logic [FUNSEL_W-1:0] CSL16 = 5'b11110;
   localparam logic [FUNSEL_W-1:0] CSR16 = 5'b11111;

   // Positions inside FlagsOut {Z,C,N,O}
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Circular shifts (8- and 16-bit CSL/CSR) share FunSel[3:1] == 3'b111;
   // their result only appears after the ALU's internal register updates.
   function automatic logic is_circular(input logic [FUNSEL_W-1:0] funsel);
      return (funsel & 5'b01110) == 5'b01110;
   endfunction

endpackage

// File: rtl/alu_command_sequencer.sv
// Drives one ALU operation per command handshake and returns the result and
// flags sampled at the edges where the ALU actually presents them.
module alu_command_sequencer
   import alu_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                CmdValid,
   output logic                CmdReady,
   input  logic [FUNSEL_W-1:0] CmdFunSel,
   input  logic [DATA_W-1:0]   CmdA,
   input  logic [DATA_W-1:0]   CmdB,
   input  logic                CmdWF,
   output logic [DATA_W-1:0]   AluA,
   output logic [DATA_W-1:0]   AluB,
   output logic [FUNSEL_W-1:0] AluFunSel,
   output logic                AluWF,
   input  logic [DATA_W-1:0]   AluOut,
   input  logic [FLAGS_W-1:0]  AluFlags,
   output logic                RspValid,
   input  logic                RspReady,
   output logic [DATA_W-1:0]   RspData,
   output logic [FLAGS_W-1:0]  RspFlags,
   output logic                Busy,
   output state_t              DbgState
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high. CmdReady depends only on state (high in IDLE); RspValid
   // stays high with RspData/RspFlags frozen until RspReady is seen.
   state_t state;

   assign DbgState = state;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         CmdReady  <= 1'b1;
         Busy      <= 1'b0;
         RspValid  <= 1'b0;
         RspData   <= '0;
         RspFlags  <= '0;
         AluA      <= '0;
         AluB      <= '0;
         AluFunSel <= '0;
         AluWF     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (CmdValid) begin
                  AluFunSel <= CmdFunSel;
                  AluA      <= CmdA;
                  AluB      <= CmdB;
                  AluWF     <= CmdWF;
                  CmdReady  <= 1'b0;
                  Busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               // Sampled before this edge's flag write, so carry-in is the old C.
               AluWF <= 1'b0;
               if (!is_circular(AluFunSel))
                  RspData <= AluOut;
               state <= CAPTURE;
            end
            CAPTURE: begin
               RspFlags <= AluFlags;
               if (is_circular(AluFunSel))
                  RspData <= AluOut;
               RspValid <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               if (RspReady) begin
                  RspValid <= 1'b0;
                  CmdReady <= 1'b1;
                  Busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_command_sequencer.sv
// Directed bench for alu_command_sequencer with a small behavioural ALU
// (combinational result, registered circular result and flags).
module tb_alu_command_sequencer;
   import alu_pkg::*;

   logic                Clock = 1'b0;
   logic                Reset;
   logic                CmdValid;
   logic                CmdReady;
   logic [FUNSEL_W-1:0] CmdFunSel;
   logic [DATA_W-1:0]   CmdA, CmdB;
   logic                CmdWF;
   logic [DATA_W-1:0]   AluA, AluB;
   logic [FUNSEL_W-1:0] AluFunSel;
   logic                AluWF;
   logic [DATA_W-1:0]   AluOut;
   logic [FLAGS_W-1:0]  AluFlags;
   logic                RspValid;
   logic                RspReady;
   logic [DATA_W-1:0]   RspData;
   logic [FLAGS_W-1:0]  RspFlags;
   logic                Busy;
   state_t              DbgState;

   int vectors    = 0;
   int miscompares = 0;

   always #5 Clock = ~Clock;

   alu_command_sequencer dut (
      .Clock(Clock), .Reset(Reset),
      .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdFunSel(CmdFunSel),
      .CmdA(CmdA), .CmdB(CmdB), .CmdWF(CmdWF),
      .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
      .AluOut(AluOut), .AluFlags(AluFlags),
      .RspValid(RspValid), .RspReady(RspReady),
      .RspData(RspData), .RspFlags(RspFlags),
      .Busy(Busy), .DbgState(DbgState)
   );

   // ALU model
   logic [3:0]  alu_flags_q = 4'h0;
   logic [15:0] csl_q       = 16'h0;
   logic        preset_en   = 1'b0;
   logic [3:0]  preset_val  = 4'h0;
   logic [15:0] comb_r;
   logic [3:0]  comb_f;
   logic [16:0] sum;
   logic        c_new, o_new;

   always_comb begin
      sum    = 17'h0;
      comb_r = 16'h0;
      c_new  = alu_flags_q[FLAG_C];
      o_new  = 1'b0;
      case (AluFunSel)
         ADD16: begin
            sum    = {1'b0, AluA} + {1'b0, AluB};
            comb_r = sum[15:0];
            c_new  = sum[16];
            o_new  = (AluA[15] == AluB[15]) && (comb_r[15] != AluA[15]);
         end
         ADC16: begin
            sum    = {1'b0, AluA} + {1'b0, AluB} + {16'h0, alu_flags_q[FLAG_C]};
            comb_r = sum[15:0];
            c_new  = sum[16];
            o_new  = (AluA[15] == AluB[15]) && (comb_r[15] != AluA[15]);
         end
         SUB16: begin
            comb_r = AluA - AluB;
            c_new  = (AluA >= AluB);
            o_new  = (AluA[15] != AluB[15]) && (comb_r[15] != AluA[15]);
         end
         CSL16: begin
            comb_r = {AluA[14:0], AluA[15]};
            c_new  = AluA[15];
         end
         default: comb_r = 16'h0;
      endcase
      comb_f = {(comb_r == 16'h0), c_new, comb_r[15], o_new};
   end

   assign AluOut   = is_circular(AluFunSel) ? csl_q : comb_r;
   assign AluFlags = alu_flags_q;

   always @(posedge Clock) begin
      csl_q <= {AluA[14:0], AluA[15]};
      if (preset_en)
         alu_flags_q <= preset_val;
      else if (AluWF)
         alu_flags_q <= comb_f;
   end

   task automatic preset_flags(input logic [3:0] f);
      preset_val = f;
      preset_en  = 1'b1;
      @(posedge Clock); #1;
      preset_en  = 1'b0;
   endtask

   // Presents a command while the DUT is idle; returns #1 after the accept edge.
   task automatic drive_cmd(input logic [4:0] fs, input logic [15:0] a,
                            input logic [15:0] b, input logic wf);
      CmdFunSel = fs; CmdA = a; CmdB = b; CmdWF = wf;
      CmdValid  = 1'b1;
      @(posedge Clock); #1;
      CmdValid  = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      vectors++; if (DbgState !== IDLE) begin miscompares++; $display("FAIL rst_state: got %0d expected %0d", DbgState, IDLE); end
      vectors++; if (CmdReady !== 1'b1) begin miscompares++; $display("FAIL rst_cmdready: got %b expected 1", CmdReady); end
      vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", Busy); end
      vectors++; if (RspValid !== 1'b0) begin miscompares++; $display("FAIL rst_rspvalid: got %b expected 0", RspValid); end
      vectors++; if ({RspData, RspFlags} !== 20'h0) begin miscompares++; $display("FAIL rst_rsp: got %h/%h expected 0000/0", RspData, RspFlags); end
      vectors++; if ({AluA, AluB, AluFunSel, AluWF} !== 38'h0) begin miscompares++; $display("FAIL rst_alu: got %h %h %b %b expected zeros", AluA, AluB, AluFunSel, AluWF); end
      Reset = 1'b0;
      @(posedge Clock); #1;
   endtask

   task automatic test_add_overflow();
      drive_cmd(ADD16, 16'h7FFF, 16'h0001, 1'b1);
      vectors++; if (AluWF !== 1'b1 || DbgState !== ISSUE) begin miscompares++; $display("FAIL add_issue: got wf=%b st=%0d expected wf=1 st=1", AluWF, DbgState); end
      vectors++; if (CmdReady !== 1'b0 || Busy !== 1'b1) begin miscompares++; $display("FAIL add_busy: got rdy=%b busy=%b expected 0/1", CmdReady, Busy); end
      @(posedge Clock); #1;
      vectors++; if (RspValid !== 1'b0) begin miscompares++; $display("FAIL add_early_valid: got %b expected 0", RspValid); end
      @(posedge Clock); #1;
      vectors++; if (RspValid !== 1'b1) begin miscompares++; $display("FAIL add_valid_t2: got %b expected 1", RspValid); end
      vectors++; if (RspData !== 16'h8000) begin miscompares++; $display("FAIL add_data: got %h expected 8000", RspData); end
      vectors++; if (RspFlags !== 4'b0011) begin miscompares++; $display("FAIL add_flags: got %b expected 0011", RspFlags); end
      @(posedge Clock); #1;
      vectors++; if (CmdReady !== 1'b1 || RspValid !== 1'b0) begin miscompares++; $display("FAIL add_release: got rdy=%b vld=%b expected 1/0", CmdReady, RspValid); end
   endtask

   task automatic test_sub_zero();
      drive_cmd(SUB16, 16'h0005, 16'h0005, 1'b1);
      vectors++; if (AluWF !== 1'b1) begin miscompares++; $display("FAIL sub_wf_issue: got %b expected 1", AluWF); end
      @(posedge Clock); #1;
      vectors++; if (AluWF !== 1'b0) begin miscompares++; $display("FAIL sub_wf_capture: got %b expected 0", AluWF); end
      vectors++; if (AluFunSel !== SUB16 || AluA !== 16'h0005) begin miscompares++; $display("FAIL sub_hold: got %b %h expected 10110 0005", AluFunSel, AluA); end
      @(posedge Clock); #1;
      vectors++; if (AluWF !== 1'b0) begin miscompares++; $display("FAIL sub_wf_resp: got %b expected 0", AluWF); end
      vectors++; if (RspData !== 16'h0000 || RspFlags !== 4'b1100) begin miscompares++; $display("FAIL sub_rsp: got %h/%b expected 0000/1100", RspData, RspFlags); end
      @(posedge Clock); #1;
   endtask

   task automatic test_adc_no_wf();
      preset_flags(4'b0100);
      drive_cmd(ADC16, 16'h0001, 16'h0001, 1'b0);
      vectors++; if (AluWF !== 1'b0) begin miscompares++; $display("FAIL adc_wf: got %b expected 0", AluWF); end
      repeat (2) begin @(posedge Clock); #1; end
      vectors++; if (RspData !== 16'h0003) begin miscompares++; $display("FAIL adc_data: got %h expected 0003", RspData); end
      vectors++; if (RspFlags !== 4'b0100) begin miscompares++; $display("FAIL adc_flags: got %b expected 0100", RspFlags); end
      @(posedge Clock); #1;
   endtask

   task automatic test_circular();
      preset_flags(4'b0100);
      drive_cmd(CSL16, 16'h8000, 16'h0000, 1'b1);
      @(posedge Clock); #1;
      vectors++; if (RspData !== 16'h0003) begin miscompares++; $display("FAIL csl_no_issue_sample: got %h expected 0003", RspData); end
      @(posedge Clock); #1;
      vectors++; if (RspData !== 16'h0001) begin miscompares++; $display("FAIL csl_data: got %h expected 0001", RspData); end
      vectors++; if (RspFlags !== 4'b0100) begin miscompares++; $display("FAIL csl_flags: got %b expected 0100", RspFlags); end
      @(posedge Clock); #1;
   endtask

   task automatic test_backpressure();
      RspReady = 1'b0;
      drive_cmd(ADD16, 16'h0001, 16'h0002, 1'b0);
      repeat (2) begin @(posedge Clock); #1; end
      CmdFunSel = CSL16; CmdA = 16'hFFFF; CmdB = 16'h0000; CmdWF = 1'b1;
      for (int i = 0; i < 5; i++) begin
         CmdValid = (i == 2);
         @(posedge Clock); #1;
         CmdValid = 1'b0;
         vectors++;
         if (RspValid !== 1'b1 || RspData !== 16'h0003 || RspFlags !== 4'b0100 ||
             CmdReady !== 1'b0 || AluWF !== 1'b0 || AluFunSel !== ADD16) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got vld=%b d=%h f=%b rdy=%b wf=%b fs=%b expected 1 0003 0100 0 0 10100",
                     i, RspValid, RspData, RspFlags, CmdReady, AluWF, AluFunSel);
         end
      end
      RspReady = 1'b1;
      @(posedge Clock); #1;
      vectors++; if (CmdReady !== 1'b1 || RspValid !== 1'b0 || AluFunSel !== ADD16) begin miscompares++; $display("FAIL bp_release: got rdy=%b vld=%b fs=%b expected 1 0 10100", CmdReady, RspValid, AluFunSel); end
   endtask

   task automatic test_reset_midop();
      drive_cmd(SUB16, 16'h0003, 16'h0003, 1'b1);
      Reset = 1'b1;
      #1;
      vectors++; if (AluWF !== 1'b0 || RspValid !== 1'b0) begin miscompares++; $display("FAIL midrst_async: got wf=%b vld=%b expected 0/0", AluWF, RspValid); end
      vectors++; if (CmdReady !== 1'b1 || DbgState !== IDLE) begin miscompares++; $display("FAIL midrst_idle: got rdy=%b st=%0d expected 1/0", CmdReady, DbgState); end
      @(posedge Clock); #1;
      vectors++; if (alu_flags_q !== 4'b0100) begin miscompares++; $display("FAIL midrst_flags: got %b expected 0100", alu_flags_q); end
      vectors++; if (RspData !== 16'h0000) begin miscompares++; $display("FAIL midrst_rspdata: got %h expected 0000", RspData); end
      Reset = 1'b0;
      drive_cmd(ADD16, 16'h0002, 16'h0003, 1'b1);
      repeat (2) begin @(posedge Clock); #1; end
      vectors++; if (RspValid !== 1'b1 || RspData !== 16'h0005 || RspFlags !== 4'b0000) begin miscompares++; $display("FAIL midrst_next: got vld=%b d=%h f=%b expected 1 0005 0000", RspValid, RspData, RspFlags); end
      @(posedge Clock); #1;
   endtask

   task automatic test_back_to_back();
      CmdFunSel = ADD16; CmdA = 16'h0010; CmdB = 16'h0020; CmdWF = 1'b0;
      CmdValid  = 1'b1;
      @(posedge Clock); #1;
      CmdFunSel = SUB16; CmdA = 16'h0030; CmdB = 16'h0010;
      @(posedge Clock); #1;
      vectors++; if (AluFunSel !== ADD16 || AluA !== 16'h0010) begin miscompares++; $display("FAIL b2b_ignore: got %b %h expected 10100 0010", AluFunSel, AluA); end
      @(posedge Clock); #1;
      vectors++; if (RspValid !== 1'b1 || RspData !== 16'h0030) begin miscompares++; $display("FAIL b2b_first: got vld=%b d=%h expected 1 0030", RspValid, RspData); end
      @(posedge Clock); #1;
      vectors++; if (CmdReady !== 1'b1) begin miscompares++; $display("FAIL b2b_idle: got %b expected 1", CmdReady); end
      @(posedge Clock); #1;
      CmdValid = 1'b0;
      vectors++; if (DbgState !== ISSUE || AluFunSel !== SUB16 || AluA !== 16'h0030) begin miscompares++; $display("FAIL b2b_accept: got st=%0d fs=%b a=%h expected 1 10110 0030", DbgState, AluFunSel, AluA); end
      repeat (2) begin @(posedge Clock); #1; end
      vectors++; if (RspData !== 16'h0020 || RspFlags !== 4'b0000) begin miscompares++; $display("FAIL b2b_second: got %h/%b expected 0020/0000", RspData, RspFlags); end
      @(posedge Clock); #1;
   endtask

   initial begin
      Reset = 1'b1; CmdValid = 1'b0; CmdFunSel = '0; CmdA = '0; CmdB = '0;
      CmdWF = 1'b0; RspReady = 1'b1;
      test_reset();
      test_add_overflow();
      test_sub_zero();
      test_adc_no_wf();
      test_circular();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_command_sequencer.md
# alu_command_sequencer

Command-side driver for the 16-bit ALU. It accepts one operation per valid/ready handshake and drives the ALU's FunSel, A, B and WF inputs with correctly timed stimulus. It samples the ALU result and FlagsOut at the correct clock edges and returns them through a valid/ready response port. It sits between the control unit and the ALU, and it hides the ALU's mixed combinational/registered output timing (circular shifts, carry-dependent results).

## Interface
- DATA_W, 16, operand/result width; fixed by the ALU.
- FUNSEL_W, 5, function-select width.
- Clock  in  1  sole clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- CmdValid  in  1  command present.
- CmdReady  out  1  block can accept a command; high only in IDLE.
- CmdFunSel  in  5  ALU function code.
- CmdA, CmdB  in  16  operands.
- CmdWF  in  1  commit flags to the ALU for this command.
- AluA, AluB  out  16  registered operands to the ALU.
- AluFunSel  out  5  registered function code to the ALU.
- AluWF  out  1  flag-write strobe to the ALU.
- AluOut  in  16  ALU result.
- AluFlags  in  4  ALU FlagsOut {Z,C,N,O}.
- RspValid  out  1  response present.
- RspReady  in  1  consumer takes the response.
- RspData  out  16  captured result.
- RspFlags  out  4  captured flags {Z,C,N,O}.
- Busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - CmdReady=1.
  - On CmdValid&CmdReady, register FunSel/A/B/WF into AluFunSel/AluA/AluB and a held WF bit, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - AluWF = held WF.
  - The ALU writes flags and registers the circular-shift result at the end-of-cycle edge.
  - For non-circular codes, RspData <= AluOut at that same edge. This sample is pre-flag-update, so ADD-with-carry uses the old carry.
  - Go to CAPTURE.
- CAPTURE (exactly 1 cycle):
  - AluWF=0; AluFunSel/A/B held.
  - At the end edge, RspFlags <= AluFlags.
  - For circular codes (FunSel[3:1]==3'b111: CSL/CSR, 8- and 16-bit), RspData <= AluOut at that same edge.
  - Go to RESP.
- RESP:
  - RspValid=1; RspData/RspFlags stable.
  - On RspReady, go to IDLE.
- Alu* outputs retain their last values in IDLE and RESP; AluWF is 0 in every state except ISSUE.
- When CmdWF=0, RspFlags returns the ALU's current (unchanged) flags.
- Results are taken verbatim from the ALU; no width conversion in this block (8-bit ops already arrive sign- or zero-extended).
- Unknown FunSel codes do not exist; all 32 codes are forwarded.

## Timing
- Reset values:
  - state=IDLE, CmdReady=1, Busy=0, RspValid=0.
  - RspData=16'h0000, RspFlags=4'h0.
  - AluA=AluB=16'h0000, AluFunSel=5'b00000, AluWF=0.
- Latency: accept edge T0; ISSUE occupies T0→T1; CAPTURE occupies T1→T2; RspValid=1 from T2.
- Throughput: at best 1 command per 4 cycles (IDLE, ISSUE, CAPTURE, RESP handshake).
- Backpressure: RspReady low holds RESP indefinitely with all outputs frozen and CmdReady=0.
- CmdValid is ignored outside IDLE; CmdValid high with no command in progress is accepted on the next edge.
- RspReady high outside RESP has no effect.
- Reset mid-operation:
  - AluWF drops asynchronously, so no flag write occurs if Reset is asserted before the ISSUE edge.
  - Any in-flight response is discarded.
  - The ALU's own flags are not reset by this block.
- After Reset deasserts, the first command is accepted on the first edge with CmdValid high.

## Structure
- Shared package alu_pkg:
  - FunSel localparams (e.g., ADD16=5'b10100, SUB16=5'b10110, CSL16=5'b11110).
  - Flag bit indices Z=3, C=2, N=1, O=0.
  - State enum.
  - Function is_circular(funsel).
- No sub-module: a single FSM plus capture registers.

## Test plan
- ADD16, WF=1, A=16'h7FFF, B=16'h0001 → RspValid at T2, RspData=16'h8000, RspFlags=4'b0011.
- SUB16, WF=1, A=B=16'h0005 → RspData=16'h0000, RspFlags=4'b1100; AluWF high for exactly one cycle.
- Preset C=1, then ADC16 (5'b10101), WF=0, A=16'h0001, B=16'h0001 → RspData=16'h0003; RspFlags equal the preset flags.
- Preset C=1, then CSL16, WF=1, A=16'h8000 → RspData=16'h0001 (sampled in CAPTURE), RspFlags=4'b0100.
- Hold RspReady low for 5 cycles after RspValid → RspData/RspFlags stable, CmdReady=0, AluWF=0; a pulsed CmdValid is not accepted.
- Assert Reset during ISSUE → AluWF=0 and RspValid=0 immediately, ALU flags unchanged, CmdReady=1; the next command completes normally.
